adder_32_sync: RTL and testbench

- Registered 32-bit binary adder with carry-in and carry-out; the arithmetic core behind the ALU's ADD, SUB, NEG and NOT operations.
- The ALU handles operand pre-processing: swapping, inversion and carry-in selection.
- Carry-lookahead structure built from 4-bit lookahead groups with a rippled group carry; one-cycle registered result with a valid flag.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/cla_4_group.sv | 44 ++++
 rtl/adder_32_sync.sv | 92 +++++++++
 tb/tb_adder_32_sync.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU datapath: default operand width, the width of
// one carry-lookahead group, and the ALU opcode encodings. The adder itself
// only needs the widths; the opcodes live here so the ALU front end and the
// adder agree on one definition.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CLA_GROUP_W   = 4;

  // ALU opcodes. ADD/SUB/NEG/NOT all resolve to the adder after the ALU
  // front end swaps/inverts operands and picks the carry-in.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_NEG = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;

endpackage

// File: rtl/cla_4_group.sv
// -----------------------------------------------------------------------------
// cla_4_group
// Combinational 4-bit carry-lookahead group. All four internal carries are
// expanded directly from generate/propagate and the group carry-in, so the
// group has no internal ripple.
//
// Ports:
//   x[3:0], y[3:0]  addend bits for this group
//   cin             carry into bit 0 of the group
//   sum[3:0]        sum bits
//   cout            carry out of bit 3
//   c3              carry into bit 3 (used for signed overflow at the MSB)
// -----------------------------------------------------------------------------
module cla_4_group
  import alu_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] x,
  input  logic [CLA_GROUP_W-1:0] y,
  input  logic                   cin,
  output logic [CLA_GROUP_W-1:0] sum,
  output logic                   cout,
  output logic                   c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = x & y;
  assign p = x ^ y;

  // c[i+1] = g[i] | p[i]&c[i], flattened into sum-of-products form.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/adder_32_sync.sv
// -----------------------------------------------------------------------------
// adder_32_sync
// Registered WIDTH-bit adder with carry-in/carry-out, built from 4-bit
// lookahead groups whose group carries ripple from one group to the next.
// One cycle of latency, one operation per cycle.
//
// Handshake: valid-only, no ready. An operation is accepted on every rising
// clk edge where in_valid=1; its result appears after that edge with
// out_valid=1 for exactly one cycle. When in_valid=0 at an edge, out_valid
// drops and out_sum/out_carry keep their last value. reset wins over in_valid.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   in_valid         operands valid this cycle
//   in_x, in_y       addends
//   in_carry         carry into bit 0
//   out_sum          registered sum
//   out_carry        registered carry out of the MSB
//   out_valid        out_sum/out_carry hold a fresh result
//   out_overflow     registered signed overflow (only with ADDER_32_OVERFLOW_EN)
//
// Build option: define ADDER_32_OVERFLOW_EN to add the out_overflow port.
// -----------------------------------------------------------------------------
module adder_32_sync
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_carry,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
`ifdef ADDER_32_OVERFLOW_EN
  output logic             out_overflow,
`endif
  output logic             out_valid
);

  localparam int NG = WIDTH / CLA_GROUP_W;

  logic [NG:0]      grp_carry;
  logic [NG-1:0]    grp_c3;
  logic [WIDTH-1:0] sum_comb;
  logic             unused_c3;

  assign grp_carry[0] = in_carry;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_4_group u_grp (
      .x    (in_x[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .y    (in_y[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .cin  (grp_carry[gi]),
      .sum  (sum_comb[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .cout (grp_carry[gi+1]),
      .c3   (grp_c3[gi])
    );
  end

  // Only the top group's c3 matters (and only for overflow); the rest are
  // intentionally left unused.
  assign unused_c3 = ^grp_c3;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sum   <= sum_comb;
        out_carry <= grp_carry[NG];
      end
    end
  end

`ifdef ADDER_32_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_overflow <= 1'b0;
    end else if (in_valid) begin
      out_overflow <= grp_c3[NG-1] ^ grp_carry[NG];
    end
  end
`endif

endmodule

// File: tb/tb_adder_32_sync.sv
// -----------------------------------------------------------------------------
// tb_adder_32_sync
// Self-checking bench for adder_32_sync. Expected results are pushed into
// exp_q when an operation is driven and popped when out_valid is seen.
// Define ADDER_32_OVERFLOW_EN to also check out_overflow.
// -----------------------------------------------------------------------------
module tb_adder_32_sync;

  localparam int W = 32;
`ifdef ADDER_32_OVERFLOW_EN
  localparam int EW = W + 2;
`else
  localparam int EW = W + 1;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         in_carry;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_valid;
`ifdef ADDER_32_OVERFLOW_EN
  logic         out_overflow;
`endif

  always #5 clk = ~clk;

  adder_32_sync #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_carry     (in_carry),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
`ifdef ADDER_32_OVERFLOW_EN
    .out_overflow (out_overflow),
`endif
    .out_valid    (out_valid)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] got_v;
  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  last_sum;
  logic          last_carry;

`ifdef ADDER_32_OVERFLOW_EN
  assign got_v = {out_overflow, out_carry, out_sum};
`else
  assign got_v = {out_carry, out_sum};
`endif

  // Behavioural reference: plain wide addition, signed overflow from signs.
  function automatic logic [EW-1:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic c);
    logic [W:0] s;
    logic       ov;
    s  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`ifdef ADDER_32_OVERFLOW_EN
    return {ov, s};
`else
    return s;
`endif
  endfunction

  function automatic logic [EW-1:0] pack_exp(input logic ov, input logic c,
                                             input logic [W-1:0] s);
`ifdef ADDER_32_OVERFLOW_EN
    return {ov, c, s};
`else
    return {c, s};
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic c);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    in_carry = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b sum=%h carry=%b, want valid=0 sum=0 carry=0",
               out_valid, out_sum, out_carry);
    end
`ifdef ADDER_32_OVERFLOW_EN
    checks++;
    if (out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b want 0", out_overflow);
    end
`endif
    // Launch an op, then assert reset with another op present: it is dropped.
    reset = 1'b0;
    drive(1'b1, 32'h1234_0000, 32'h0000_5678, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h1234_5678) begin
      errors++;
      $display("FAIL pre_reset_op: valid=%b sum=%h, want valid=1 sum=12345678",
               out_valid, out_sum);
    end
    reset = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_override: valid=%b sum=%h carry=%b, want 0/0/0",
               out_valid, out_sum, out_carry);
    end
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    last_sum   = '0;
    last_carry = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] tx[10]  = '{32'h0000_FFFF, 32'hFFFF_FF00, 32'hFFFF_FFFE, 32'h0F0F_0F0F,
                              32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h1234_5678, 32'h0000_000F};
    logic [W-1:0] ty[10]  = '{32'h0000_0001, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000,
                              32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h9ABC_DEF0, 32'h0000_0001};
    logic         tc[10]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] ts[10]  = '{32'h0001_0000, 32'h0000_FF00, 32'hFFFF_FFFF, 32'h0F0F_0F0F,
                              32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                              32'hACF1_3568, 32'h0000_0010};
    logic         tco[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic         tov[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tx[i], ty[i], tc[i]);
      exp_q.push_back(pack_exp(tov[i], tco[i], ts[i]));
      tick();
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL directed_valid[%0d]: valid=%b queued=%0d, want valid=1", i,
                 out_valid, exp_q.size());
      end else begin
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL directed[%0d]: got %h want %h", i, got_v, exp_v);
        end
      end
      drive(1'b0, '0, '0, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_idle[%0d]: valid=%b want 0", i, out_valid);
      end
      last_sum   = ts[i];
      last_carry = tco[i];
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] bx[3] = '{32'h0000_0001, 32'hFFFF_0000, 32'h8000_0001};
    logic [W-1:0] by[3] = '{32'h0000_0002, 32'h0001_0000, 32'h7FFF_FFFF};
    logic         bc[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bx[i], by[i], bc[i]);
      exp_q.push_back(model(bx[i], by[i], bc[i]));
      tick();
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: valid=%b want 1", i, out_valid);
      end else begin
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL b2b[%0d]: got %h want %h", i, got_v, exp_v);
        end
        last_sum   = exp_v[W-1:0];
        last_carry = exp_v[W];
      end
    end
    // Idle cycles with junk operands: valid drops, outputs hold.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_sum !== last_sum || out_carry !== last_carry) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b sum=%h carry=%b, want 0 %h %b", i,
                 out_valid, out_sum, out_carry, last_sum, last_carry);
      end
    end
  endtask

  task automatic test_random();
    logic         v;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 9) < 8);
      x = $urandom;
      y = $urandom;
      c = 1'($urandom_range(0, 1));
      // Bias some vectors toward carry-chain corners.
      if ($urandom_range(0, 7) == 0) y = ~x;
      if ($urandom_range(0, 15) == 0) x = 32'hFFFF_FFFF;
      drive(v, x, y, c);
      if (v) exp_q.push_back(model(x, y, c));
      tick();
      checks++;
      if (out_valid !== v) begin
        errors++;
        $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, v);
        if (v && exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (v) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL rand[%0d]: x=%h y=%h c=%b got %h want %h", i, x, y, c,
                   got_v, exp_v);
        end
        last_sum   = exp_v[W-1:0];
        last_carry = exp_v[W];
      end else begin
        checks++;
        if (out_sum !== last_sum || out_carry !== last_carry) begin
          errors++;
          $display("FAIL rand_hold[%0d]: sum=%h carry=%b want %h %b", i,
                   out_sum, out_carry, last_sum, last_carry);
        end
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
